// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM encoding for the system controller.
package sys_ctrl_pkg;

  localparam int unsigned OPC_WIDTH = 8;
  localparam int unsigned FUN_WIDTH = 4;

  localparam logic [OPC_WIDTH-1:0] OPC_RF_WR   = 8'hAA;
  localparam logic [OPC_WIDTH-1:0] OPC_RF_RD   = 8'hBB;
  localparam logic [OPC_WIDTH-1:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [OPC_WIDTH-1:0] OPC_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_RD_SEND  = 4'd5,
    ST_OP_A     = 4'd6,
    ST_OP_B     = 4'd7,
    ST_ALU_FUN  = 4'd8,
    ST_ALU_WAIT = 4'd9,
    ST_SEND_LO  = 4'd10,
    ST_SEND_HI  = 4'd11
  } state_e;

  // States in which the ALU clock must be running.
  function automatic logic alu_clk_needed(state_e s);
    return s inside {ST_OP_A, ST_OP_B, ST_ALU_FUN, ST_ALU_WAIT};
  endfunction

endpackage

// File: rtl/sys_ctrl.sv
// Command-frame controller: decodes UART bytes into register-file and ALU
// operations and pushes response bytes into the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]     RF_Address,
  output logic                      RF_WrEn,
  output logic                      RF_RdEn,
  output logic [DATA_WIDTH-1:0]     RF_WrData,
  input  logic [DATA_WIDTH-1:0]     RF_RdData,
  input  logic                      RF_RdData_VLD,
  output logic [FUN_WIDTH-1:0]      ALU_FUN,
  output logic                      ALU_EN,
  output logic                      CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  input  logic                      FIFO_FULL,
  output logic                      cmd_err
);

  localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RES_WIDTH-1:0]    res_q, res_d;

  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic                    rf_wren_q, rf_wren_d;
  logic                    rf_rden_q, rf_rden_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic                    clk_gate_q, clk_gate_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    cmd_err_q, cmd_err_d;

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    res_d      = res_q;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    alu_fun_d  = alu_fun_q;
    tx_data_d  = tx_data_q;
    rf_wren_d  = 1'b0;
    rf_rden_d  = 1'b0;
    alu_en_d   = 1'b0;
    tx_vld_d   = 1'b0;
    cmd_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(OPC_RF_WR))        state_d = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(OPC_RF_RD))   state_d = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP))  state_d = ST_OP_A;
          else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP)) state_d = ST_ALU_FUN;
          else                                            cmd_err_d = 1'b1;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wren_d  = 1'b1;
          rf_addr_d  = addr_q;
          rf_wdata_d = RX_P_DATA;
          state_d    = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_rden_d = 1'b1;
          rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = ST_RD_WAIT;
        end
      end
      // With room in the FIFO the byte goes out straight away, saving a cycle.
      ST_RD_WAIT: begin
        if (RF_RdData_VLD) begin
          res_d = RES_WIDTH'(RF_RdData);
          if (!FIFO_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = RF_RdData;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_RD_SEND;
          end
        end
      end
      ST_RD_SEND: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_WIDTH-1:0];
          state_d   = ST_IDLE;
        end
      end
      ST_OP_A: begin
        if (RX_D_VLD) begin
          rf_wren_d  = 1'b1;
          rf_addr_d  = ADDR_WIDTH'(OPA_ADDR);
          rf_wdata_d = RX_P_DATA;
          state_d    = ST_OP_B;
        end
      end
      ST_OP_B: begin
        if (RX_D_VLD) begin
          rf_wren_d  = 1'b1;
          rf_addr_d  = ADDR_WIDTH'(OPB_ADDR);
          rf_wdata_d = RX_P_DATA;
          state_d    = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_d = ALU_OUT;
          if (!FIFO_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
            state_d   = ST_SEND_HI;
          end else begin
            state_d   = ST_SEND_LO;
          end
        end
      end
      ST_SEND_LO: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_WIDTH-1:0];
          state_d   = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[RES_WIDTH-1:DATA_WIDTH];
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clk_gate_d = alu_clk_needed(state_d);
  end

  // State and output registers; reset clears everything in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      res_q      <= '0;
      rf_addr_q  <= '0;
      rf_wren_q  <= 1'b0;
      rf_rden_q  <= 1'b0;
      rf_wdata_q <= '0;
      alu_fun_q  <= '0;
      alu_en_q   <= 1'b0;
      clk_gate_q <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      res_q      <= res_d;
      rf_addr_q  <= rf_addr_d;
      rf_wren_q  <= rf_wren_d;
      rf_rden_q  <= rf_rden_d;
      rf_wdata_q <= rf_wdata_d;
      alu_fun_q  <= alu_fun_d;
      alu_en_q   <= alu_en_d;
      clk_gate_q <= clk_gate_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign RF_Address  = rf_addr_q;
  assign RF_WrEn     = rf_wren_q;
  assign RF_RdEn     = rf_rden_q;
  assign RF_WrData   = rf_wdata_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: frame-level reference model, RF/ALU responders,
// directed frames with literal expectations, then randomized frames.
module tb_sys_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   RX_P_DATA;
  logic            RX_D_VLD;
  logic [AW-1:0]   RF_Address;
  logic            RF_WrEn;
  logic            RF_RdEn;
  logic [DW-1:0]   RF_WrData;
  logic [DW-1:0]   RF_RdData;
  logic            RF_RdData_VLD;
  logic [3:0]      ALU_FUN;
  logic            ALU_EN;
  logic            CLK_GATE_EN;
  logic [2*DW-1:0] ALU_OUT;
  logic            ALU_OUT_VLD;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD;
  logic            FIFO_FULL;
  logic            cmd_err;

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL),
    .cmd_err(cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: bytes of the open frame, outstanding
  // responses and the queue of bytes still owed to the TX FIFO.
  logic [7:0]    m_frame[$];
  logic [7:0]    m_txq[$];
  bit            m_wait_rd, m_wait_alu;
  logic          e_wren, e_rden, e_alu_en, e_gate, e_tx_vld, e_err;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_wdata, e_tx;
  logic [3:0]    e_fun;

  function automatic bit model_busy();
    return m_frame.size() != 0 || m_wait_rd || m_wait_alu || m_txq.size() != 0;
  endfunction

  task automatic model_decode();
    int n;
    logic [7:0] last;
    n    = m_frame.size();
    last = m_frame[n-1];
    case (m_frame[0])
      8'hAA: if (n == 3) begin
        e_wren = 1'b1; e_addr = AW'(m_frame[1]); e_wdata = last; m_frame.delete();
      end
      8'hBB: if (n == 2) begin
        e_rden = 1'b1; e_addr = AW'(last); m_wait_rd = 1'b1; m_frame.delete();
      end
      8'hCC: if (n == 2 || n == 3) begin
        e_wren = 1'b1; e_addr = AW'(n - 2); e_wdata = last;
      end else if (n == 4) begin
        e_alu_en = 1'b1; e_fun = last[3:0]; m_wait_alu = 1'b1; m_frame.delete();
      end
      8'hDD: if (n == 2) begin
        e_alu_en = 1'b1; e_fun = last[3:0]; m_wait_alu = 1'b1; m_frame.delete();
      end
      default: begin
        e_err = 1'b1; m_frame.delete();
      end
    endcase
  endtask

  task automatic model_step();
    e_wren = 1'b0; e_rden = 1'b0; e_alu_en = 1'b0; e_tx_vld = 1'b0; e_err = 1'b0;
    if (!rst_n) begin
      m_frame.delete(); m_txq.delete();
      m_wait_rd = 1'b0; m_wait_alu = 1'b0;
      e_addr = '0; e_wdata = '0; e_tx = '0; e_fun = '0; e_gate = 1'b0;
      return;
    end
    if (m_wait_rd) begin
      if (RF_RdData_VLD) begin m_txq.push_back(RF_RdData); m_wait_rd = 1'b0; end
    end else if (m_wait_alu) begin
      if (ALU_OUT_VLD) begin
        m_txq.push_back(ALU_OUT[7:0]); m_txq.push_back(ALU_OUT[15:8]); m_wait_alu = 1'b0;
      end
    end else if (m_txq.size() == 0 && RX_D_VLD) begin
      m_frame.push_back(RX_P_DATA);
      model_decode();
    end
    if (m_txq.size() != 0 && !FIFO_FULL) begin
      e_tx_vld = 1'b1; e_tx = m_txq.pop_front();
    end
    e_gate = m_wait_alu || (m_frame.size() != 0 && (m_frame[0] == 8'hCC || m_frame[0] == 8'hDD));
  endtask

  initial begin
    e_fun = '0; e_gate = 1'b0; e_addr = '0; e_wdata = '0; e_tx = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Observed-activity logs used by the directed literal checks.
  logic [7:0]  tx_log[$];
  logic [11:0] wr_log[$];
  logic [3:0]  alu_log[$];
  int          err_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("RF_WrEn", 32'(RF_WrEn), 32'(e_wren));
        chk("RF_RdEn", 32'(RF_RdEn), 32'(e_rden));
        chk("ALU_EN", 32'(ALU_EN), 32'(e_alu_en));
        chk("ALU_FUN", 32'(ALU_FUN), 32'(e_fun));
        chk("CLK_GATE_EN", 32'(CLK_GATE_EN), 32'(e_gate));
        chk("TX_D_VLD", 32'(TX_D_VLD), 32'(e_tx_vld));
        chk("cmd_err", 32'(cmd_err), 32'(e_err));
        if (e_wren || e_rden) chk("RF_Address", 32'(RF_Address), 32'(e_addr));
        if (e_wren) chk("RF_WrData", 32'(RF_WrData), 32'(e_wdata));
        if (e_tx_vld) chk("TX_P_DATA", 32'(TX_P_DATA), 32'(e_tx));
        if (TX_D_VLD) tx_log.push_back(TX_P_DATA);
        if (RF_WrEn) wr_log.push_back({RF_Address, RF_WrData});
        if (ALU_EN) alu_log.push_back(ALU_FUN);
        if (cmd_err) err_cnt++;
      end
    end
  end

  // Register file and ALU responders with random response latency.
  logic [7:0]  rf_mem[16];
  bit          rd_pend, alu_pend;
  int          rd_dly, alu_dly;
  logic [7:0]  rd_val;
  logic [15:0] alu_val;
  bit          alu_ovr_en = 1'b0;
  logic [15:0] alu_ovr = '0;

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    RF_RdData = '0; RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    rd_pend = 1'b0; alu_pend = 1'b0; rd_dly = 0; alu_dly = 0;
    forever begin
      @(posedge clk); #2;
      RF_RdData_VLD = 1'b0;
      ALU_OUT_VLD   = 1'b0;
      if (!rst_n) begin
        rd_pend = 1'b0; alu_pend = 1'b0;
      end else begin
        if (RF_WrEn) rf_mem[RF_Address] = RF_WrData;
        if (RF_RdEn) begin
          rd_pend = 1'b1; rd_dly = $urandom_range(0, 3); rd_val = rf_mem[RF_Address];
        end
        if (ALU_EN) begin
          alu_pend = 1'b1; alu_dly = $urandom_range(0, 3);
          if (alu_ovr_en) alu_val = alu_ovr;
          else if (ALU_FUN == 4'd0) alu_val = 16'(rf_mem[0]) + 16'(rf_mem[1]);
          else alu_val = 16'($urandom);
        end
        if (rd_pend) begin
          if (rd_dly == 0) begin RF_RdData_VLD = 1'b1; RF_RdData = rd_val; rd_pend = 1'b0; end
          else rd_dly--;
        end
        if (alu_pend) begin
          if (alu_dly == 0) begin ALU_OUT_VLD = 1'b1; ALU_OUT = alu_val; alu_pend = 1'b0; end
          else alu_dly--;
        end
      end
    end
  end

  bit full_rand = 1'b0;
  bit full_force = 1'b0;

  initial begin
    FIFO_FULL = 1'b0;
    forever begin
      @(posedge clk); #1;
      FIFO_FULL = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0;
  endtask

  task automatic wait_idle(input bit stray);
    int cyc;
    cyc = 0;
    while (model_busy() && cyc < 400) begin
      if (stray && m_frame.size() == 0 && $urandom_range(0, 2) == 0) begin
        RX_P_DATA = 8'($urandom); RX_D_VLD = 1'b1;
      end else begin
        RX_D_VLD = 1'b0;
      end
      tick();
      cyc++;
    end
    RX_D_VLD = 1'b0;
    chk("idle_timeout", 32'(cyc >= 400), 32'(0));
    tick(); tick();
  endtask

  task automatic clear_logs();
    tx_log.delete(); wr_log.delete(); alu_log.delete(); err_cnt = 0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_TX_D_VLD", 32'(TX_D_VLD), 32'(0));
    chk("rst_RF_Address", 32'(RF_Address), 32'(0));
    chk("rst_ALU_FUN", 32'(ALU_FUN), 32'(0));
    chk("rst_TX_P_DATA", 32'(TX_P_DATA), 32'(0));
    chk("rst_CLK_GATE_EN", 32'(CLK_GATE_EN), 32'(0));
    rst_n = 1'b1;
    tick();

    // RF write frame.
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_idle(1'b0);
    chk("wr_count", 32'(wr_log.size()), 32'(1));
    if (wr_log.size() == 1) chk("wr_addr_data", 32'(wr_log[0]), 32'h53C);
    chk("wr_no_tx", 32'(tx_log.size()), 32'(0));

    // RF read frame returns the written byte.
    clear_logs();
    send_byte(8'hBB); send_byte(8'h05);
    wait_idle(1'b0);
    chk("rd_tx_count", 32'(tx_log.size()), 32'(1));
    if (tx_log.size() == 1) chk("rd_tx_byte", 32'(tx_log[0]), 32'h3C);

    // ALU with operands: 7 + 3.
    clear_logs();
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h00);
    wait_idle(1'b0);
    chk("op_wr_count", 32'(wr_log.size()), 32'(2));
    if (wr_log.size() == 2) begin
      chk("op_a_write", 32'(wr_log[0]), 32'h007);
      chk("op_b_write", 32'(wr_log[1]), 32'h103);
    end
    chk("op_alu_count", 32'(alu_log.size()), 32'(1));
    if (alu_log.size() == 1) chk("op_alu_fun", 32'(alu_log[0]), 32'(0));
    chk("op_tx_count", 32'(tx_log.size()), 32'(2));
    if (tx_log.size() == 2) begin
      chk("op_tx_lo", 32'(tx_log[0]), 32'h0A);
      chk("op_tx_hi", 32'(tx_log[1]), 32'h00);
    end

    // ALU without operands under FIFO backpressure.
    clear_logs();
    alu_ovr_en = 1'b1; alu_ovr = 16'h1234; full_force = 1'b1;
    tick();
    send_byte(8'hDD); send_byte(8'h02);
    cyc = 0;
    while (m_txq.size() != 2 && cyc < 50) begin tick(); cyc++; end
    chk("full_result_timeout", 32'(cyc >= 50), 32'(0));
    repeat (5) tick();
    chk("full_no_push", 32'(tx_log.size()), 32'(0));
    full_force = 1'b0;
    wait_idle(1'b0);
    if (alu_log.size() == 1) chk("nop_alu_fun", 32'(alu_log[0]), 32'(2));
    chk("full_tx_count", 32'(tx_log.size()), 32'(2));
    if (tx_log.size() == 2) begin
      chk("full_tx_lo", 32'(tx_log[0]), 32'h34);
      chk("full_tx_hi", 32'(tx_log[1]), 32'h12);
    end
    alu_ovr_en = 1'b0;

    // Unknown opcode, then a normal write frame.
    clear_logs();
    send_byte(8'h55);
    wait_idle(1'b0);
    chk("err_count", 32'(err_cnt), 32'(1));
    send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h5A);
    wait_idle(1'b0);
    chk("err_then_wr_count", 32'(wr_log.size()), 32'(1));
    if (wr_log.size() == 1) chk("err_then_wr", 32'(wr_log[0]), 32'hA5A);

    // Reset in the middle of an ALU frame, then a read from IDLE.
    clear_logs();
    send_byte(8'hCC); send_byte(8'h07);
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick(); tick();
    chk("rst_mid_wr_count", 32'(wr_log.size()), 32'(1));
    chk("rst_mid_alu_count", 32'(alu_log.size()), 32'(0));
    send_byte(8'hBB); send_byte(8'h00);
    wait_idle(1'b0);
    chk("rst_then_rd_count", 32'(tx_log.size()), 32'(1));
    if (tx_log.size() == 1) chk("rst_then_rd_byte", 32'(tx_log[0]), 32'h07);

    // Randomized frames with backpressure, stray bytes and occasional resets.
    full_rand = 1'b1; alu_ovr_en = 1'b1;
    for (int f = 0; f < 200; f++) begin
      logic [7:0] fr[$];
      logic [7:0] junk;
      int r, k;
      fr.delete();
      alu_ovr = 16'($urandom);
      r = $urandom_range(0, 8);
      if (r < 2) begin
        fr.push_back(8'hAA); fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
      end else if (r < 4) begin
        fr.push_back(8'hBB); fr.push_back(8'($urandom));
      end else if (r < 6) begin
        fr.push_back(8'hCC); fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
      end else if (r < 8) begin
        fr.push_back(8'hDD); fr.push_back(8'($urandom));
      end else begin
        junk = 8'($urandom);
        if (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'h55;
        fr.push_back(junk);
      end
      if ($urandom_range(0, 19) == 0) begin
        k = $urandom_range(1, fr.size());
        for (int i = 0; i < k; i++) begin
          send_byte(fr[i]);
          repeat ($urandom_range(0, 2)) tick();
        end
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
      end else begin
        foreach (fr[i]) begin
          send_byte(fr[i]);
          repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(1'b1);
      end
    end
    full_rand = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
